count_display: RTL and testbench

Downstream display stage for the exam datapath: consumes the 7-bit `count` and `done` produced by the LabExam controller and drives the board's 8-digit multiplexed seven-segment display. On each `load` strobe it captures `count` and converts it to three BCD digits with a sequential shift-add-3 converter. It then scans the digits continuously with leading-zero blanking, and shows a `d` on digit 7 while `done` is high. It replaces direct segment generation inside the controller, so the controller only has to present a binary value.

---
 rtl/display_pkg.sv | 47 ++++
 rtl/count_display_if.sv | 17 +
 rtl/bin2bcd7.sv | 68 ++++++
 rtl/count_display.sv | 142 ++++++++++++++
 tb/tb_count_display.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the count display slice.
// Holds the conversion FSM states, digit count and active-low segment glyphs.
// Also provides the BCD nibble to segment lookup used by the scan mux.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 8;
  localparam int CNT_W      = 7;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/count_display_if.sv
// Bundle between the exam controller and the display stage.
// The controller side drives count/load/done and observes busy and the display pins.
// The display side consumes count/load/done and drives out7/en_out/busy.
interface count_display_if;
  import display_pkg::*;

  logic [CNT_W-1:0]      count;
  logic                  load;
  logic                  done;
  logic [6:0]            out7;
  logic [NUM_DIGITS-1:0] en_out;
  logic                  busy;

  modport master (output count, load, done, input out7, en_out, busy);
  modport slave  (input count, load, done, output out7, en_out, busy);

endinterface

// File: rtl/bin2bcd7.sv
// Sequential shift-add-3 converter, 7-bit binary to hundreds/tens/ones BCD.
// Latency: captured on start, seven shift cycles; valid flags the final shift cycle.
// No backpressure: a start while running is not expected and simply restarts.
module bin2bcd7
  import display_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [CNT_W-1:0] bin,
  output logic [3:0]       hund,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             valid
);

  logic [CNT_W-1:0] sh_q, sh_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [7:0]       adj;
  logic [2:0]       cnt_q, cnt_d;
  logic             run_q, run_d;

  // Capture on start, otherwise adjust-then-shift one bit per cycle, MSB first.
  // Hundreds never exceeds 1 for a 7-bit input, so only tens/ones need the +3 step.
  always_comb begin
    adj = bcd_q[7:0];
    for (int i = 0; i < 2; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      sh_d  = bin;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {bcd_q[10:8], adj, sh_q[CNT_W-1]};
      sh_d  = {sh_q[CNT_W-2:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'(CNT_W - 1)) run_d = 1'b0;
    end
  end

  // Converter state registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // Results are stable from the edge that ends the valid cycle until the next start.
  assign valid = run_q && (cnt_q == 3'(CNT_W - 1));
  assign hund  = bcd_q[11:8];
  assign tens  = bcd_q[7:4];
  assign ones  = bcd_q[3:0];

endmodule

// File: rtl/count_display.sv
// Captures count on load, converts to BCD and scans 8 multiplexed seven-segment digits.
// Latency: load at edge N commits at N+8; out7/en_out follow the digit index by one cycle.
// No stall: loads during a conversion queue one entry, last value wins.
module count_display
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic Clk,
  input  logic Rst,
  count_display_if.slave bus
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [CNT_W-1:0]      pend_val_q, pend_val_d;
  logic [3:0]            hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic [REF_W-1:0]      ref_q, ref_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            out7_q, out7_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;

  logic                  conv_start, conv_valid, digit_on;
  logic [CNT_W-1:0]      conv_bin;
  logic [3:0]            conv_hund, conv_tens, conv_ones;
  logic [6:0]            seg;

  bin2bcd7 u_bin2bcd7 (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (conv_start),
    .bin   (conv_bin),
    .hund  (conv_hund),
    .tens  (conv_tens),
    .ones  (conv_ones),
    .valid (conv_valid)
  );

  // Conversion sequencing, one-deep load queue and display register commit.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    pend_val_d = pend_val_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    conv_start = 1'b0;
    conv_bin   = bus.count;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          conv_start = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        if (bus.load) begin
          pending_d  = 1'b1;
          pend_val_d = bus.count;
        end
        if (conv_valid) state_d = COMMIT;
      end
      COMMIT: begin
        hund_d = conv_hund;
        tens_d = conv_tens;
        ones_d = conv_ones;
        if (pending_q) begin
          // The queued value restarts now; a load on this same cycle becomes the new queue entry.
          conv_start = 1'b1;
          conv_bin   = pend_val_q;
          state_d    = CONV;
          pending_d  = bus.load;
          if (bus.load) pend_val_d = bus.count;
        end else if (bus.load) begin
          // Nothing queued: a load landing here is queued and consumed on the same edge.
          conv_start = 1'b1;
          state_d    = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Refresh divider and digit index, plus the blanking segment mux for the current digit.
  always_comb begin
    ref_d = ref_q + REF_W'(1);
    idx_d = idx_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end
    digit_on = 1'b0;
    seg      = SEG_BLANK;
    case (idx_q)
      3'd0: begin digit_on = 1'b1; seg = seg_of(ones_q); end
      3'd1: if (hund_q != 4'd0 || tens_q != 4'd0) begin digit_on = 1'b1; seg = seg_of(tens_q); end
      3'd2: if (hund_q != 4'd0) begin digit_on = 1'b1; seg = seg_of(hund_q); end
      3'd7: if (bus.done) begin digit_on = 1'b1; seg = SEG_D; end
      default: ;
    endcase
    out7_d = digit_on ? seg : SEG_BLANK;
    en_d   = digit_on ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  end

  // All state registers; both display outputs update on the same edge.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      pend_val_q <= '0;
      hund_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      ref_q      <= '0;
      idx_q      <= '0;
      out7_q     <= SEG_BLANK;
      en_q       <= '1;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      pend_val_q <= pend_val_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      ref_q      <= ref_d;
      idx_q      <= idx_d;
      out7_q     <= out7_d;
      en_q       <= en_d;
    end
  end

  assign bus.out7   = out7_q;
  assign bus.en_out = en_q;
  assign bus.busy   = (state_q != IDLE) || pending_q;

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display with a fast refresh divider of 4.
// Drives and samples on the falling clock edge, away from the active edge.
// Every expected value is a hand-derived constant checked through one task.
module tb_count_display;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000, GD = 7'b0100001;

  logic Clk;
  logic Rst;
  count_display_if bus_if ();

  count_display #(.REFRESH_DIV(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_if)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [6:0] seg_seen [8];
  logic [7:0] seen_mask;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic pulse_load(input logic [6:0] v);
    @(negedge Clk);
    bus_if.count = v;
    bus_if.load  = 1'b1;
    @(negedge Clk);
    bus_if.load  = 1'b0;
  endtask

  // Load a value and count the cycles busy stays high afterwards.
  task automatic load_and_measure(input logic [6:0] v, output int run);
    pulse_load(v);
    run = 0;
    while (bus_if.busy && run < 40) begin
      run++;
      @(negedge Clk);
    end
  endtask

  // Observe one full 8-digit scan, recording which digits lit and their glyphs.
  task automatic do_scan();
    int bad;
    logic [7:0] act;
    bad = 0;
    seen_mask = '0;
    for (int k = 0; k < 8; k++) seg_seen[k] = 7'h7F;
    @(negedge Clk);
    repeat (32) begin
      act = ~bus_if.en_out;
      for (int k = 0; k < 8; k++)
        if (act[k]) begin seen_mask[k] = 1'b1; seg_seen[k] = bus_if.out7; end
      if (act != 8'h00 && $countones(act) != 1) bad++;
      if (act == 8'h00 && bus_if.out7 != 7'h7F) bad++;
      @(negedge Clk);
    end
    check("scan_shape", 32'(bad), 32'd0);
  endtask

  // Align to the first sample of digit 0 in the scan.
  task automatic sync_digit0();
    logic [7:0] prev;
    bit hit;
    prev = bus_if.en_out;
    hit = 1'b0;
    for (int c = 0; c < 80 && !hit; c++) begin
      @(negedge Clk);
      if (bus_if.en_out == 8'hFE && prev != 8'hFE) hit = 1'b1;
      else prev = bus_if.en_out;
    end
    check("sync_digit0", 32'(hit), 32'd1);
  endtask

  initial begin
    int run;
    int first_lo;
    int nine_cnt;

    Rst = 1'b0;
    bus_if.count = '0;
    bus_if.load  = 1'b0;
    bus_if.done  = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_out7", 32'(bus_if.out7), 32'h7F);
    check("rst_en", 32'(bus_if.en_out), 32'hFF);
    check("rst_busy", 32'(bus_if.busy), 32'd0);

    // Release; the first edge lights digit 0 with a zero, others blank at value 0.
    Rst = 1'b1;
    @(negedge Clk);
    check("first_en", 32'(bus_if.en_out), 32'hFE);
    check("first_out7", 32'(bus_if.out7), 32'(G0));
    for (int k = 1; k <= 8; k++) begin
      repeat (4) @(negedge Clk);
      check("idle_scan_en", 32'(bus_if.en_out), (k % 8 == 0) ? 32'hFE : 32'hFF);
    end

    // 127: three digits lit.
    load_and_measure(7'd127, run);
    check("busy_127", 32'(run), 32'd8);
    do_scan();
    check("mask_127", 32'(seen_mask), 32'h07);
    check("d2_127", 32'(seg_seen[2]), 32'(G1));
    check("d1_127", 32'(seg_seen[1]), 32'(G2));
    check("d0_127", 32'(seg_seen[0]), 32'(G7));

    // 5: leading zeros blanked.
    load_and_measure(7'd5, run);
    check("busy_5", 32'(run), 32'd8);
    do_scan();
    check("mask_5", 32'(seen_mask), 32'h01);
    check("d0_5", 32'(seg_seen[0]), 32'(G5));

    // 100: tens zero stays lit under a non-zero hundreds.
    load_and_measure(7'd100, run);
    check("busy_100", 32'(run), 32'd8);
    do_scan();
    check("mask_100", 32'(seen_mask), 32'h07);
    check("d2_100", 32'(seg_seen[2]), 32'(G1));
    check("d1_100", 32'(seg_seen[1]), 32'(G0));
    check("d0_100", 32'(seg_seen[0]), 32'(G0));

    // 42 at N, 99 at N+3, 7 at N+5; N placed so digits 0/1 scan right after the 42 commit.
    sync_digit0();
    repeat (22) @(negedge Clk);
    bus_if.count = 7'd42;
    bus_if.load  = 1'b1;
    @(negedge Clk);
    bus_if.load  = 1'b0;
    first_lo = -1;
    nine_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus_if.busy && first_lo < 0) first_lo = i;
      if (bus_if.en_out != 8'hFF && bus_if.out7 == G9) nine_cnt++;
      if (i == 9) begin
        check("q42_d0_en", 32'(bus_if.en_out), 32'hFE);
        check("q42_d0_seg", 32'(bus_if.out7), 32'(G2));
      end
      if (i == 13) begin
        check("q42_d1_en", 32'(bus_if.en_out), 32'hFD);
        check("q42_d1_seg", 32'(bus_if.out7), 32'(G4));
      end
      if (i == 2) begin bus_if.count = 7'd99; bus_if.load = 1'b1; end
      if (i == 4) begin bus_if.count = 7'd7;  bus_if.load = 1'b1; end
      if (i == 3 || i == 5) bus_if.load = 1'b0;
      @(negedge Clk);
    end
    check("queue_busy_run", 32'(first_lo), 32'd16);
    check("queue_no_99", 32'(nine_cnt), 32'd0);
    do_scan();
    check("mask_7", 32'(seen_mask), 32'h01);
    check("d0_7", 32'(seg_seen[0]), 32'(G7));

    // done lights digit 7 with a 'd', then blanks again.
    bus_if.done = 1'b1;
    do_scan();
    check("mask_done", 32'(seen_mask), 32'h81);
    check("d7_done", 32'(seg_seen[7]), 32'(GD));
    bus_if.done = 1'b0;
    do_scan();
    check("mask_undone", 32'(seen_mask), 32'h01);

    // Reset during the fourth CONV cycle aborts and clears the display.
    pulse_load(7'd127);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("midrst_out7", 32'(bus_if.out7), 32'h7F);
    check("midrst_en", 32'(bus_if.en_out), 32'hFF);
    check("midrst_busy", 32'(bus_if.busy), 32'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("post_rst_en", 32'(bus_if.en_out), 32'hFE);
    check("post_rst_out7", 32'(bus_if.out7), 32'(G0));
    do_scan();
    check("post_rst_mask", 32'(seen_mask), 32'h01);
    check("post_rst_d0", 32'(seg_seen[0]), 32'(G0));
    check("post_rst_busy", 32'(bus_if.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
